axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI4 slave memory model answering the data cache's refill, writeback and uncached traffic. It stores a word-addressed array with byte-lane writes, one burst transaction at a time. It sits on the far side of the dcache AXI master port and is used as the system-bus endpoint in core-level simulation and on-chip scratch configurations.

## Interface
Parameters:
- DEPTH_WORDS, 4096: array depth in 32-bit words; power of two.
- ID_WIDTH, 4: width of the AXI ID fields.
- MAX_LEN, 15: largest accepted arlen/awlen, i.e. 16 beats, matching the dcache line word count.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/32/8/3/2  read address channel
- arvalid  in  1 / arready  out  1  read address handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/32/2/1  read data channel
- rvalid  out  1 / rready  in  1  read data handshake
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/32/8/3/2  write address channel
- awvalid  in  1 / awready  out  1  write address handshake
- wdata/wstrb/wlast  in  32/4/1  write data channel
- wvalid  in  1 / wready  out  1  write data handshake
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid  out  1 / bready  in  1  write response handshake
- proto_err  out  1  sticky flag for a protocol or capability violation

## Operation
- FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP.
- In IDLE:
  - awready = 1.
  - arready = !awvalid, so a write wins when both address channels are valid in the same cycle. This keeps a dirty-line writeback ahead of the refill that follows it.
  - All other readys and valids are 0.
- AR handshake: latch id, address, len and burst type; beat counter = 0; go to RD_BURST.
- RD_BURST:
  - rvalid = 1, rdata = mem[addr_q], rid = latched id, rresp = OKAY.
  - rlast = 1 when beat counter == len.
  - On each rvalid&&rready: advance the address and increment the counter.
  - On the last beat: return to IDLE.
- AW handshake: latch fields; go to WR_DATA.
- WR_DATA:
  - wready = 1.
  - On each wvalid&&wready: write each byte lane whose wstrb bit is set, then advance the address and counter.
  - When the handshake carries wlast: go to WR_RESP.
- WR_RESP:
  - bvalid = 1, bid = latched id, bresp = OKAY.
  - On bready: return to IDLE.
- Address advance:
  - INCR (2'b01) and WRAP (2'b10): +4.
  - FIXED (2'b00): address unchanged.
  - WRAP is deliberately treated as INCR.
- Array index = addr[log2(DEPTH_WORDS)+1:2]; out-of-range addresses alias modulo the depth. Address bits [1:0] are ignored.
- proto_err sets, and stays set until reset, on any of:
  - arsize or awsize != 3'b010;
  - len > MAX_LEN;
  - burst type 2'b11;
  - wlast present on a beat other than beat len;
  - wlast missing on beat len.
- Recovery from an early or missing wlast:
  - the burst ends at the first wlast;
  - beats beyond len are still written at the incremented addresses.
- Array contents are not cleared by reset.

## Timing
- All outputs are registered or decoded from state and registers. No combinational path from any valid input to any ready output, except arready's dependence on awvalid.
- Reset value of every output: 0, including proto_err, all valids, readys, ids, rdata, rlast and resp fields. State returns to IDLE.
- Read latency: AR handshake in cycle T, first rvalid in T+1. With rready held high, beat k arrives in T+1+k.
- Write: AW handshake in T, wready from T+1. wlast handshake in cycle U, bvalid in U+1.
- A read of an address written by an earlier completed write (bvalid handshake done) returns the new data.
- Backpressure: while rvalid && !rready, rdata/rid/rlast hold stable. bvalid holds until bready.
- Reset asserted mid-burst: next cycle is IDLE with all valids low. Remaining beats are dropped. A partially written line keeps the beats already written.

## Structure
- Shared package axi_resp_pkg holds:
  - state enum (IDLE, RD_BURST, WR_DATA, WR_RESP);
  - burst constants BURST_FIXED/INCR/WRAP;
  - resp constants RESP_OKAY/SLVERR;
  - SIZE_WORD = 3'b010.
- One sub-module: byte_en_ram.
  - DEPTH_WORDS × 32 array.
  - Combinational read.
  - Synchronous write with 4-bit byte enable.

## Test plan
- Reset, then a 16-beat INCR write to 0x100 with data 0x1000+k and wstrb 4'hF, then a 16-beat INCR read of 0x100 -> bvalid in the cycle after wlast; rdata beat k = 0x1000+k; rlast only on beat 15; rresp = 0.
- Single-beat writes to 0x200: first wdata 0xAABBCCDD with wstrb 4'hF, then wdata 0x11223344 with wstrb 4'b0101; read 0x200 -> 0xAA22CC44.
- arvalid and awvalid asserted in the same IDLE cycle -> awready = 1, arready = 0. The read is accepted only after the write's bvalid&&bready, and it returns the newly written data.
- 4-beat read with rready toggled 1,0,0,1,1,0,1 -> rdata/rlast stable across stalls; exactly 4 beats delivered; return to IDLE.
- AW with awlen = 3 whose wlast arrives on beat 1 -> burst ends; bvalid the next cycle; proto_err = 1 and stays 1 until rst.
- rst asserted on beat 5 of an 8-beat read -> rvalid = 0 and FSM in IDLE the following cycle. Data written earlier is still readable after reset.

Source files
------------

// File: rtl/axi_resp_pkg.sv
// Shared types and AXI encodings for the memory responder.
package axi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_DATA  = 2'd2,
    WR_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // Any address-phase request this responder cannot honour exactly.
  function automatic logic bad_req(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [7:0] max_len);
    return (size != SIZE_WORD) || (len > max_len) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Word array with combinational read and byte-lane synchronous write.
module byte_en_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: one burst at a time, writes win address arbitration.
//
// state    | meaning
// IDLE     | waiting for AW (preferred) or AR
// RD_BURST | presenting read beats until rlast is accepted
// WR_DATA  | accepting write beats until wlast
// WR_RESP  | holding bvalid until bready
module axi_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ID_WIDTH    = 4,
  parameter int MAX_LEN     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                proto_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t                state;
  logic                  idle_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [AW-1:0]         addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic [AW-1:0]         addr_nxt;
  logic [31:0]           ram_rdata;
  logic                  ram_we;
  logic                  unused_addr_bits;

  // Only the word-index bits matter; everything above aliases.
  assign unused_addr_bits = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

  assign addr_nxt = (burst_q == BURST_FIXED) ? addr_q : addr_q + AW'(1);
  assign ram_we   = wready && wvalid;

  assign awready = idle_q;
  assign arready = idle_q && !awvalid;
  assign rid     = id_q;
  assign bid     = id_q;
  assign rresp   = RESP_OKAY;
  assign bresp   = RESP_OKAY;
  assign rdata   = rvalid ? ram_rdata : 32'h0;

  byte_en_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (wstrb),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idle_q    <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= BURST_FIXED;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_q <= 1'b1;
          if (idle_q && awvalid) begin
            id_q    <= awid;
            addr_q  <= awaddr[AW+1:2];
            len_q   <= awlen;
            burst_q <= awburst;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
            wready  <= 1'b1;
            state   <= WR_DATA;
            if (bad_req(awsize, awlen, awburst, MAX_LEN_B)) proto_err <= 1'b1;
          end else if (idle_q && arvalid) begin
            id_q    <= arid;
            addr_q  <= araddr[AW+1:2];
            len_q   <= arlen;
            burst_q <= arburst;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            state   <= RD_BURST;
            if (bad_req(arsize, arlen, arburst, MAX_LEN_B)) proto_err <= 1'b1;
          end
        end
        RD_BURST: begin
          if (rready) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 8'd1;
            rlast  <= ((cnt_q + 8'd1) == len_q);
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              idle_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 8'd1;
            if (wlast != (cnt_q == len_q)) proto_err <= 1'b1;
            // The first wlast always closes the burst, early or late.
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            idle_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder with a word-array reference model.
module tb_axi_mem_responder;
  import axi_resp_pkg::*;

  localparam int ID = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ID-1:0] arid = '0, awid = '0, rid, bid;
  logic [31:0]   araddr = '0, awaddr = '0, rdata, wdata = '0;
  logic [7:0]    arlen = '0, awlen = '0;
  logic [2:0]    arsize = SIZE_WORD, awsize = SIZE_WORD;
  logic [1:0]    arburst = BURST_INCR, awburst = BURST_INCR, rresp, bresp;
  logic          arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic          awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
  logic [3:0]    wstrb = '0;
  logic          bvalid, bready = 0, proto_err;

  int n_checks = 0;
  int n_err = 0;
  int last_cycles;
  logic [31:0] rd0;
  logic [31:0] model [4096];

  axi_mem_responder #(.DEPTH_WORDS(4096), .ID_WIDTH(ID), .MAX_LEN(15)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input int last_beat,
                           input logic [ID-1:0] id, input logic [31:0] d0, input logic [3:0] strb);
    int n;
    int idx;
    awaddr = addr; awlen = len; awid = id; awsize = SIZE_WORD; awburst = BURST_INCR; awvalid = 1;
    n = 0; #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    if (!awready) timeout("aw_wait");
    @(negedge clk);
    awvalid = 0;
    for (int k = 0; k <= last_beat; k++) begin
      wvalid = 1; wdata = d0 + k; wstrb = strb; wlast = (k == last_beat);
      n = 0; #1;
      while (!wready && n < 50) begin @(negedge clk); #1; n++; end
      if (!wready) timeout("w_wait");
      idx = ((addr >> 2) + k) % 4096;
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    #1;
    check("bvalid_after_wlast", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, RESP_OKAY);
    bready = 1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [ID-1:0] id,
                          input logic [15:0] pat, input int pat_n, input int abort_beat);
    int n, cyc, beat, idx;
    bit done;
    araddr = addr; arlen = len; arid = id; arburst = BURST_INCR; arvalid = 1;
    n = 0; #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (!arready) timeout("ar_wait");
    @(negedge clk);
    arvalid = 0;
    arsize = SIZE_WORD;
    cyc = 0; beat = 0; done = 0;
    while (!done && cyc < 100) begin
      rready = (cyc < pat_n) ? pat[cyc] : 1'b1;
      #1;
      if (cyc == 0) check("rvalid_latency", rvalid, 1);
      if (abort_beat >= 0 && beat == abort_beat) begin
        rst = 1;
        @(negedge clk); #1;
        check("rvalid_after_rst", rvalid, 0);
        check("state_after_rst", dut.state, IDLE);
        rst = 0; rready = 0;
        @(negedge clk); #1;
        check("awready_after_rst", awready, 1);
        return;
      end
      if (rvalid) begin
        idx = ((addr >> 2) + beat) % 4096;
        check($sformatf("rdata_b%0d", beat), rdata, model[idx]);
        check($sformatf("rlast_b%0d", beat), rlast, (beat == len));
        check("rid", rid, id);
        check("rresp", rresp, RESP_OKAY);
        if (beat == 0) rd0 = rdata;
        if (rready) begin
          beat++;
          if (beat == len + 1) done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 0;
    last_cycles = cyc;
    check("beats_delivered", beat, len + 1);
    #1;
    check("rvalid_done", rvalid, 0);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h200,  32'hAABBCCDD, 4'hF, 32'h200, 32'hAABBCCDD};
    vecs[1] = '{32'h200,  32'h11223344, 4'h5, 32'h200, 32'hAA22CC44};
    vecs[2] = '{32'h200,  32'h00FF0000, 4'h4, 32'h200, 32'hAAFFCC44};
    vecs[3] = '{32'h300,  32'hDEADBEEF, 4'hF, 32'h300, 32'hDEADBEEF};
    vecs[4] = '{32'h4300, 32'h12345678, 4'h3, 32'h300, 32'hDEAD5678};
    vecs[5] = '{32'h302,  32'hCAFEF00D, 4'hC, 32'h300, 32'hCAFE5678};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    rst = 0;
    @(negedge clk);

    // 16-beat line write then refill
    axi_write(32'h100, 8'd15, 15, 4'd1, 32'h1000, 4'hF);
    axi_read(32'h100, 8'd15, 4'd2, 16'h0, 0, -1);
    check("line_rd_cycles", last_cycles, 16);
    check("line_rd_beat0", rd0, 32'h1000);

    // Single-beat byte-lane vectors
    for (int i = 0; i < 6; i++) begin
      axi_write(vecs[i].waddr, 8'd0, 0, 4'd3, vecs[i].wd, vecs[i].strb);
      axi_read(vecs[i].raddr, 8'd0, 4'd4, 16'h0, 0, -1);
      check($sformatf("vec%0d_rdata", i), rd0, vecs[i].exp);
    end

    // Simultaneous AW and AR: write first, read sees the new data
    @(negedge clk);
    awaddr = 32'h400; awlen = 0; awid = 4'd3; awburst = BURST_INCR; awvalid = 1;
    araddr = 32'h400; arlen = 0; arid = 4'd5; arburst = BURST_INCR; arvalid = 1;
    #1;
    check("arb_awready", awready, 1);
    check("arb_arready", arready, 0);
    @(negedge clk);
    awvalid = 0;
    #1;
    check("arb_arready_wr", arready, 0);
    wvalid = 1; wdata = 32'h5A5A1234; wstrb = 4'hF; wlast = 1;
    model[32'h400 >> 2] = 32'h5A5A1234;
    @(negedge clk);
    wvalid = 0; wlast = 0;
    #1;
    check("arb_bvalid", bvalid, 1);
    check("arb_arready_resp", arready, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    #1;
    check("arb_arready_idle", arready, 1);
    @(negedge clk);
    arvalid = 0;
    #1;
    check("arb_rvalid", rvalid, 1);
    check("arb_rdata", rdata, 32'h5A5A1234);
    check("arb_rid", rid, 5);
    rready = 1;
    @(negedge clk);
    rready = 0;

    // Backpressure 1,0,0,1,1,0,1 on a 4-beat read
    axi_read(32'h100, 8'd3, 4'd6, 16'h0059, 7, -1);
    check("bp_cycles", last_cycles, 7);

    // Early wlast
    check("perr_clean", proto_err, 0);
    axi_write(32'h500, 8'd3, 1, 4'd7, 32'h7000, 4'hF);
    check("perr_early_wlast", proto_err, 1);
    axi_read(32'h500, 8'd1, 4'd8, 16'h0, 0, -1);
    check("perr_sticky", proto_err, 1);

    // Reset on beat 5 of an 8-beat read
    axi_read(32'h100, 8'd7, 4'd9, 16'h0, 0, 5);
    check("perr_cleared", proto_err, 0);
    axi_read(32'h100, 8'd3, 4'd9, 16'h0, 0, -1);
    check("post_rst_data", rd0, 32'h1000);

    // Unsupported arsize
    arsize = 3'b000;
    axi_read(32'h100, 8'd0, 4'd1, 16'h0, 0, -1);
    check("perr_arsize", proto_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
